// File: rtl/multi_mode_counter_pkg.sv
// Shared constants for multi_mode_counter: saturation mode encodings and the
// legal parameter ranges checked at elaboration.
package multi_mode_counter_pkg;

  localparam int unsigned SAT_MODE_WRAP = 0;
  localparam int unsigned SAT_MODE_HOLD = 1;

  localparam int unsigned WIDTH_MIN    = 2;
  localparam int unsigned WIDTH_MAX    = 32;
  localparam int unsigned PRESCALE_MIN = 1;
  localparam int unsigned PRESCALE_MAX = 256;

endpackage

// File: rtl/multi_mode_counter_prescaler.sv
// Enable-gated prescaler: tick is high on every PRESCALE-th enabled cycle,
// and constantly high when PRESCALE is 1.
module counter_prescaler
  import multi_mode_counter_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LP_LAST = CW'(PRESCALE - 1);

  if (PRESCALE < PRESCALE_MIN || PRESCALE > PRESCALE_MAX) begin : g_bad_prescale
    $error("counter_prescaler: PRESCALE out of range");
  end

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_d;
  logic          w_last;

  // With PRESCALE=1 the phase stays at 0, which is also the last phase.
  assign w_last = (r_cnt == LP_LAST);
  assign tick   = w_last;

  always_comb begin
    w_cnt_d = r_cnt;
    if (clr) begin
      w_cnt_d = '0;
    end else if (en) begin
      w_cnt_d = w_last ? '0 : r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_d;
    end
  end

endmodule

// File: rtl/multi_mode_counter.sv
// Up/down modulo counter with load, prescaler, wrap/saturate mode, a wrap
// pulse and a sticky overflow flag.
module multi_mode_counter
  import multi_mode_counter_pkg::*;
#(
  parameter int unsigned     WIDTH    = 4,
  parameter longint unsigned MOD_MAX  = (64'd1 << WIDTH) - 64'd1,
  parameter int unsigned     PRESCALE = 1,
  parameter int unsigned     SATURATE = SAT_MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("multi_mode_counter: WIDTH out of range");
  end
  if (MOD_MAX < 64'd1 || MOD_MAX > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_mod_max
    $error("multi_mode_counter: MOD_MAX out of range");
  end
  if (SATURATE != SAT_MODE_WRAP && SATURATE != SAT_MODE_HOLD) begin : g_bad_saturate
    $error("multi_mode_counter: SATURATE must be 0 or 1");
  end

  localparam logic [WIDTH-1:0] LP_MAX  = WIDTH'(MOD_MAX);
  localparam bit               LP_HOLD = (SATURATE == SAT_MODE_HOLD);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_ovf;

  logic [WIDTH-1:0] w_count_d;
  logic             w_tick;
  logic             w_step;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_limit;
  logic             w_ovf_d;

  counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (load),
    .tick (w_tick)
  );

  assign w_at_max  = (r_count == LP_MAX);
  assign w_at_zero = (r_count == '0);
  assign w_step    = en & ~load & w_tick;
  // Limit is decided on the current count, before any increment/decrement.
  assign w_limit   = w_step & (up_dn ? w_at_max : w_at_zero);

  always_comb begin
    w_count_d = r_count;
    if (load) begin
      w_count_d = (load_val > LP_MAX) ? LP_MAX : load_val;
    end else if (w_step) begin
      if (up_dn) begin
        if (w_at_max) w_count_d = LP_HOLD ? LP_MAX : '0;
        else          w_count_d = r_count + WIDTH'(1);
      end else begin
        if (w_at_zero) w_count_d = LP_HOLD ? '0 : LP_MAX;
        else           w_count_d = r_count - WIDTH'(1);
      end
    end
  end

  always_comb begin
    w_ovf_d = r_ovf;
    if (w_limit)      w_ovf_d = 1'b1;
    else if (clr_ovf) w_ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_count <= w_count_d;
      r_wrap  <= w_limit;
      r_ovf   <= w_ovf_d;
    end
  end

  assign count = r_count;
  assign wrap  = r_wrap;
  assign ovf   = r_ovf;
  assign tc    = up_dn ? w_at_max : w_at_zero;

endmodule

// File: tb/tb_multi_mode_counter.sv
// Directed bench: three counter variants (wrap, saturate, prescale-by-3)
// share one stimulus stream; each scenario checks the relevant variant.
module tb_multi_mode_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up_dn;
  logic       load;
  logic [3:0] load_val;
  logic       clr_ovf;

  logic [3:0] count_a, count_b, count_c;
  logic       tc_a, tc_b, tc_c;
  logic       wrap_a, wrap_b, wrap_c;
  logic       ovf_a, ovf_b, ovf_c;

  int n_total = 0;
  int n_bad   = 0;

  multi_mode_counter #(
    .WIDTH (4), .MOD_MAX (9), .PRESCALE (1), .SATURATE (0)
  ) u_dut_wrap (
    .clk (clk), .rst (rst), .en (en), .up_dn (up_dn), .load (load),
    .load_val (load_val), .clr_ovf (clr_ovf),
    .count (count_a), .tc (tc_a), .wrap (wrap_a), .ovf (ovf_a)
  );

  multi_mode_counter #(
    .WIDTH (4), .MOD_MAX (9), .PRESCALE (1), .SATURATE (1)
  ) u_dut_sat (
    .clk (clk), .rst (rst), .en (en), .up_dn (up_dn), .load (load),
    .load_val (load_val), .clr_ovf (clr_ovf),
    .count (count_b), .tc (tc_b), .wrap (wrap_b), .ovf (ovf_b)
  );

  multi_mode_counter #(
    .WIDTH (4), .MOD_MAX (9), .PRESCALE (3), .SATURATE (0)
  ) u_dut_ps3 (
    .clk (clk), .rst (rst), .en (en), .up_dn (up_dn), .load (load),
    .load_val (load_val), .clr_ovf (clr_ovf),
    .count (count_c), .tc (tc_c), .wrap (wrap_c), .ovf (ovf_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance one edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; load = 1'b0; clr_ovf = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up_dn = 1'b0; load = 1'b0; load_val = 4'd0; clr_ovf = 1'b0;
    step();
    step();
    chk("rst_count", int'(count_a), 0);
    chk("rst_wrap", int'(wrap_a), 0);
    chk("rst_ovf", int'(ovf_a), 0);
    chk("rst_tc_dn", int'(tc_a), 1);
    up_dn = 1'b1;
    #1;
    chk("rst_tc_up", int'(tc_a), 0);

    // Modulo wrap at MOD_MAX=9
    rst = 1'b0; en = 1'b1; up_dn = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      chk($sformatf("mod_count%0d", i), int'(count_a), i % 10);
      chk($sformatf("mod_wrap%0d", i), int'(wrap_a), (i == 10) ? 1 : 0);
      chk($sformatf("mod_ovf%0d", i), int'(ovf_a), (i == 10) ? 1 : 0);
      if (i == 9) chk("mod_tc_at_max", int'(tc_a), 1);
    end
    chk("sat_hold_at_max", int'(count_b), 9);
    chk("sat_wrap_at_max", int'(wrap_b), 1);
    en = 1'b0;
    step();
    chk("mod_wrap_once", int'(wrap_a), 0);
    chk("mod_ovf_sticky", int'(ovf_a), 1);

    // Saturation at zero
    do_reset();
    load = 1'b1; load_val = 4'd1;
    step();
    chk("sat_load", int'(count_b), 1);
    load = 1'b0; up_dn = 1'b0; en = 1'b1;
    step();
    chk("sat_c1_count", int'(count_b), 0);
    chk("sat_c1_wrap", int'(wrap_b), 0);
    step();
    chk("sat_c2_count", int'(count_b), 0);
    chk("sat_c2_wrap", int'(wrap_b), 1);
    step();
    chk("sat_c3_count", int'(count_b), 0);
    chk("sat_c3_wrap", int'(wrap_b), 1);
    chk("sat_c3_ovf", int'(ovf_b), 1);
    chk("wrapmode_dn_from0", int'(count_a), 8);
    en = 1'b0;
    step();
    chk("sat_wrap_clear", int'(wrap_b), 0);

    // Load clamp, load keeps ovf, rst beats load
    load = 1'b1; load_val = 4'd13; en = 1'b1; up_dn = 1'b1;
    step();
    chk("clamp_count", int'(count_a), 9);
    chk("clamp_wrap", int'(wrap_a), 0);
    chk("clamp_ovf_kept", int'(ovf_a), 1);
    rst = 1'b1;
    step();
    chk("rst_over_load", int'(count_a), 0);
    chk("rst_over_load_ovf", int'(ovf_a), 0);

    // Prescale by 3, with an en=0 gap mid-phase
    rst = 1'b0; load = 1'b0; en = 1'b1; up_dn = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      step();
      chk($sformatf("ps_count%0d", i), int'(count_c), i / 3);
    end
    step();
    chk("ps_phase1", int'(count_c), 3);
    en = 1'b0;
    step();
    step();
    chk("ps_hold", int'(count_c), 3);
    en = 1'b1;
    step();
    chk("ps_phase2", int'(count_c), 3);
    step();
    chk("ps_step4", int'(count_c), 4);
    chk("ps_no_wrap", int'(wrap_c), 0);
    chk("ps_no_ovf", int'(ovf_c), 0);
    chk("ps_tc", int'(tc_c), 0);

    // ovf set beats clr_ovf on the same edge
    do_reset();
    load = 1'b1; load_val = 4'd9;
    step();
    load = 1'b0; en = 1'b1; up_dn = 1'b1; clr_ovf = 1'b1;
    step();
    chk("race_count", int'(count_a), 0);
    chk("race_wrap", int'(wrap_a), 1);
    chk("race_ovf", int'(ovf_a), 1);
    en = 1'b0;
    step();
    chk("clr_ovf", int'(ovf_a), 0);
    chk("clr_wrap", int'(wrap_a), 0);
    clr_ovf = 1'b0;

    // Mid-run reset with a limit step pending
    load = 1'b1; load_val = 4'd9;
    step();
    load = 1'b0; en = 1'b1;
    step();
    chk("pre_rst_ovf", int'(ovf_a), 1);
    load = 1'b1; load_val = 4'd9; en = 1'b0;
    step();
    load = 1'b0; en = 1'b1; up_dn = 1'b1; rst = 1'b1;
    step();
    chk("midrst_count", int'(count_a), 0);
    chk("midrst_wrap", int'(wrap_a), 0);
    chk("midrst_ovf", int'(ovf_a), 0);
    up_dn = 1'b0;
    #1;
    chk("midrst_tc", int'(tc_a), 1);
    rst = 1'b0; up_dn = 1'b1;
    step();
    chk("resume_count", int'(count_a), 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
